data_mem_banked: RTL and testbench
==================================

// Module: data_mem_banked
// PURPOSE
//  Parametrised byte-lane data memory for the monocycle/pipelined datapath.
//  Holds NUM_LANES banks of 8-bit RAM. Stores and loads are aligned byte,
//  half and word, with lane masking and sign/zero extension. Port 1 is a
//  registered load/store port with valid/err; port 2 is a read-only word
//  port for debug/display. After reset, a clear engine zeroes the whole array.
// PARAMETERS
//  ADDR_WIDTH      11  word-address bits; depth = 2**ADDR_WIDTH words
//  NUM_LANES       4   byte lanes per word; fixed at 4 (DATA_WIDTH = 32)
//  CLEAR_ON_RESET  1   1: run the clear sweep after reset; 0: go ready immediately
// PORTS
//  clk      in   1   clock, rising edge
//  rst_n    in   1   synchronous reset, active-low
//  ready    out  1   high when the memory accepts requests
//  req      in   1   port-1 request strobe; sampled on clk
//  we       in   1   1: store, 0: load
//  ctrl     in   3   000 B signed, 001 H signed, 010 W, 100 B unsigned, 101 H unsigned
//  addr     in   32  port-1 byte address
//  wdata    in   32  store data; low byte/half/word used per ctrl
//  rdata    out  32  load result, extended
//  rvalid   out  1   one-cycle pulse: rdata valid
//  err      out  1   one-cycle pulse: misaligned or illegal ctrl; access dropped
//  addr_2   in   32  port-2 byte address (word-aligned; addr_2[1:0] ignored)
//  rdata_2  out  32  port-2 word read
// BEHAVIOUR
//  Reset (rst_n=0 at edge): ready=0, rvalid=0, err=0, rdata=0, rdata_2=0.
//   Clear counter=0. FSM enters CLEAR if CLEAR_ON_RESET=1, else IDLE.
//   RAM contents are not touched during reset itself.
//  FSM CLEAR: one word per cycle, all lanes written with 0.
//   Counter counts 0 .. 2**ADDR_WIDTH-1. Entry to IDLE is the cycle after
//   the last word is written; ready rises on that same edge.
//  FSM IDLE: ready=1. Terminal state until the next reset.
//   Reset asserted mid-CLEAR restarts the sweep at word 0.
//  req while ready=0 is ignored: no write, no rvalid, no err.
//  Word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so the
//   address wraps modulo depth. off = addr[1:0].
//  Alignment check:
//   B: any off is legal.
//   H: off[0] must be 0.
//   W: off must be 00.
//   ctrl 011/110/111 is always illegal; 100/101 with we=1 is legal, stored as B/H.
//  Illegal access: no RAM write. err=1 for exactly the cycle after req.
//   rvalid=0 and rdata holds its previous value.
//  Store (legal): lane mask B=0001<<off, H=0011<<off, W=1111.
//   Write data is the low byte/half replicated across lanes.
//   Only masked lanes are written, at the req edge. rvalid stays 0.
//  Load (legal): RAM read is synchronous. rvalid=1 and rdata are valid in
//   the cycle after req, so latency is 1. Selected byte/half is taken from
//   lane off, then sign- or zero-extended per ctrl.
//  Back-to-back req every cycle is supported. Each req produces its own
//   rvalid/err in the following cycle.
//  Port 2: rdata_2 holds the full word at addr_2, registered with 1-cycle
//   latency, every cycle, independent of req and ready.
//   It is write-first: a same-cycle store to the same word shows the merged
//   new word on rdata_2. During CLEAR, rdata_2 returns undefined data.
//  Port-1 load and a port-2 read of the same word in the same cycle: both
//   see the same stored data.
// TESTING
//  1. Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> ready=0 for 16 cycles,
//     then 1; a W load of every word returns 0.
//  2. W store 0xDEADBEEF @0x8, then W load @0x8 -> next cycle rvalid=1,
//     rdata=0xDEADBEEF.
//  3. B store 0x7F @0x9 and H store 0x8001 @0xA over a word holding 0 ->
//     W load = 0x80017F00.
//     B signed load @0xB gives 0xFFFFFF80; B unsigned gives 0x00000080;
//     H signed @0xA gives 0xFFFF8001.
//  4. H store @0x3 and W load @0x2 -> err pulses 1 cycle each, rvalid=0,
//     memory unchanged; ctrl=011 -> err.
//  5. Store 0x12345678 @0x10 while addr_2=0x10 in the same cycle ->
//     rdata_2=0x12345678 next cycle. Access @0x10+4*depth aliases to @0x10.
//  6. Assert rst_n=0 mid-CLEAR (word 7) -> sweep restarts at word 0.
//     req before ready produces no rvalid and no err.

Source files
------------

// File: rtl/data_mem_banked.sv
// Byte-lane data memory: NUM_LANES banks of 8-bit RAM behind an aligned
// byte/half/word load-store port (port 1, latency 1) and a read-only
// write-first word port (port 2). A clear sweep zeroes the array after reset.
module data_mem_banked #(
    parameter int ADDR_WIDTH     = 11,
    parameter int NUM_LANES      = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ready,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        err,
    input  logic [31:0] addr_2,
    output logic [31:0] rdata_2
);

    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int DATA_WIDTH = 8 * NUM_LANES;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt_reg, clr_cnt_next;
    logic                    clr_we;
    logic                    ready_reg;

    logic [ADDR_WIDTH-1:0]   idx1, idx2;
    logic [1:0]              off;
    logic                    legal;
    logic [NUM_LANES-1:0]    mask;
    logic [DATA_WIDTH-1:0]   wrep;
    logic                    accept, store_en, load_en, bad;

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_idx;
    logic [NUM_LANES-1:0]    wr_mask;
    logic [DATA_WIDTH-1:0]   wr_data;

    logic [DATA_WIDTH-1:0]   raw1;
    logic                    rvalid_reg, err_reg;
    logic [2:0]              ctrl_q_reg;
    logic [1:0]              off_q_reg;
    logic [DATA_WIDTH-1:0]   rdata_hold_reg;
    logic [7:0]              sel_byte;
    logic [15:0]             sel_half;

    // Address bits above the array and the port-2 byte offset are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr_2[31:ADDR_WIDTH+2], addr_2[1:0]};

    assign idx1   = addr[ADDR_WIDTH+1:2];
    assign idx2   = addr_2[ADDR_WIDTH+1:2];
    assign off    = addr[1:0];
    assign ready  = ready_reg;
    assign rvalid = rvalid_reg;
    assign err    = err_reg;

    // Decode access size: legality, lane mask and lane-replicated store data.
    always_comb begin
        legal = 1'b0;
        mask  = '0;
        wrep  = wdata;
        case (ctrl)
            3'b000, 3'b100: begin
                legal = 1'b1;
                mask  = NUM_LANES'(4'b0001) << off;
                wrep  = {4{wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                legal = ~off[0];
                mask  = NUM_LANES'(4'b0011) << off;
                wrep  = {2{wdata[15:0]}};
            end
            3'b010: begin
                legal = (off == 2'b00);
                mask  = '1;
            end
            default: ;
        endcase
    end

    assign accept   = req & ready_reg;
    assign store_en = accept & legal & we;
    assign load_en  = accept & legal & ~we;
    assign bad      = accept & ~legal;

    // Clear FSM: sweep one word per cycle, then sit in IDLE until reset.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        clr_we       = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                clr_we       = 1'b1;
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (&clr_cnt_reg) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: ;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state, sweep counter and ready flag (ready follows entry to IDLE).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt_reg <= '0;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            ready_reg   <= (state_next == ST_IDLE);
        end
    end

    // Shared write port: the sweep owns it during CLEAR; reset blocks all writes.
    assign wr_en   = rst_n & (clr_we | store_en);
    assign wr_idx  = clr_we ? clr_cnt_reg : idx1;
    assign wr_mask = clr_we ? '1 : mask;
    assign wr_data = clr_we ? '0 : wrep;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] q1_reg;
            logic [7:0] q2_reg;
            logic       lane_we;

            assign lane_we = wr_en & wr_mask[gi];

            // Byte-lane write.
            always_ff @(posedge clk) begin
                if (lane_we) begin
                    mem[wr_idx] <= wr_data[gi*8 +: 8];
                end
            end

            // Port-1 registered read of the whole lane.
            always_ff @(posedge clk) begin
                q1_reg <= mem[idx1];
            end

            // Port-2 registered read, forwarding a same-cycle write to the same word.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q2_reg <= '0;
                end else if (lane_we && (wr_idx == idx2)) begin
                    q2_reg <= wr_data[gi*8 +: 8];
                end else begin
                    q2_reg <= mem[idx2];
                end
            end

            assign raw1[gi*8 +: 8]    = q1_reg;
            assign rdata_2[gi*8 +: 8] = q2_reg;
        end
    endgenerate

    // Response pipeline: remember what the load asked for, pulse rvalid/err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_reg     <= 1'b0;
            err_reg        <= 1'b0;
            ctrl_q_reg     <= '0;
            off_q_reg      <= '0;
            rdata_hold_reg <= '0;
        end else begin
            rvalid_reg     <= load_en;
            err_reg        <= bad;
            rdata_hold_reg <= rdata;
            if (load_en) begin
                ctrl_q_reg <= ctrl;
                off_q_reg  <= off;
            end
        end
    end

    // Lane select and extension; rdata holds its last value between loads.
    always_comb begin
        sel_byte = raw1[8*off_q_reg +: 8];
        sel_half = off_q_reg[1] ? raw1[31:16] : raw1[15:0];
        rdata    = rdata_hold_reg;
        if (rvalid_reg) begin
            case (ctrl_q_reg[1:0])
                2'b00:   rdata = ctrl_q_reg[2] ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
                2'b01:   rdata = ctrl_q_reg[2] ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
                default: rdata = raw1;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_banked.sv
// Scoreboard bench for data_mem_banked (ADDR_WIDTH=4, 16 words).
module tb_data_mem_banked;

    localparam int AW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  ctrl = 3'b010;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic [31:0] addr_2 = '0;
    logic [31:0] rdata_2;

    data_mem_banked #(.ADDR_WIDTH(AW), .NUM_LANES(4), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready), .req(req), .we(we), .ctrl(ctrl),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .err(err),
        .addr_2(addr_2), .rdata_2(rdata_2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        e;
        logic [31:0] d;
        logic [31:0] d2;
    } exp_t;

    exp_t        sb[$];
    exp_t        ex;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  mem_m [64];
    logic [31:0] hold_m = '0;

    function automatic logic [31:0] mdl_load(input logic [2:0] c, input int base);
        logic [7:0]  b;
        logic [15:0] h;
        case (c[1:0])
            2'b00: begin
                b = mem_m[base];
                return c[2] ? {24'h0, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
                h = {mem_m[base+1], mem_m[base]};
                return c[2] ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
        endcase
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
    endtask

    // Drive one request, predict its response, wait until it is observable.
    task automatic send(input logic w, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] a2);
        exp_t x;
        logic ok;
        int   base;
        int   w2;
        req = 1'b1; we = w; ctrl = c; addr = a; wdata = d; addr_2 = a2;
        base = int'(a[AW+1:0]);
        w2   = int'({a2[AW+1:2], 2'b00});
        case (c)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = (a[0] == 1'b0);
            3'b010:         ok = (a[1:0] == 2'b00);
            default:        ok = 1'b0;
        endcase
        x.v = 1'b0;
        x.e = ~ok;
        x.d = hold_m;
        if (ok && w) begin
            mem_m[base] = d[7:0];
            if (c[1:0] != 2'b00) mem_m[base+1] = d[15:8];
            if (c[1:0] == 2'b10) begin
                mem_m[base+2] = d[23:16];
                mem_m[base+3] = d[31:24];
            end
        end else if (ok) begin
            x.v    = 1'b1;
            x.d    = mdl_load(c, base);
            hold_m = x.d;
        end
        x.d2 = {mem_m[w2+3], mem_m[w2+2], mem_m[w2+1], mem_m[w2]};
        sb.push_back(x);
        @(posedge clk);
        #1;
        $display("txn we=%0b ctrl=%03b addr=%08h wdata=%08h addr_2=%08h -> rvalid=%0b err=%0b rdata=%08h rdata_2=%08h",
                 w, c, a, d, a2, rvalid, err, rdata, rdata_2);
    endtask

    task automatic wait_ready(output int n);
        n   = -1;
        req = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) begin
                n = i;
                break;
            end
        end
        mdl_clear();
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_checks += 5;
        if (ready === 1'b0) n_pass++; else $display("FAIL reset_ready got %0b want 0", ready);
        if (rvalid === 1'b0) n_pass++; else $display("FAIL reset_rvalid got %0b want 0", rvalid);
        if (err === 1'b0) n_pass++; else $display("FAIL reset_err got %0b want 0", err);
        if (rdata === 32'h0) n_pass++; else $display("FAIL reset_rdata got %08h want 0", rdata);
        if (rdata_2 === 32'h0) n_pass++; else $display("FAIL reset_rdata_2 got %08h want 0", rdata_2);
        hold_m = '0;
        rst_n  = 1'b1;
        wait_ready(n);
        n_checks++;
        if (n == 16) n_pass++; else $display("FAIL clear_cycles got %0d want 16", n);
        for (int i = 0; i < 16; i++) begin
            send(1'b0, 3'b010, 32'(i * 4), 32'h0, 32'(i * 4));
            ex = sb.pop_front();
            n_checks += 4;
            if (rvalid === ex.v) n_pass++; else $display("FAIL clr_load[%0d] rvalid got %0b want %0b", i, rvalid, ex.v);
            if (err === ex.e) n_pass++; else $display("FAIL clr_load[%0d] err got %0b want %0b", i, err, ex.e);
            if (rdata === ex.d) n_pass++; else $display("FAIL clr_load[%0d] rdata got %08h want %08h", i, rdata, ex.d);
            if (rdata_2 === ex.d2) n_pass++; else $display("FAIL clr_load[%0d] rdata_2 got %08h want %08h", i, rdata_2, ex.d2);
        end
        req = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] ta [2] = '{32'h8, 32'h8};
        logic        tw [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            send(tw[i], 3'b010, ta[i], 32'hDEADBEEF, 32'h4);
            ex = sb.pop_front();
            n_checks += 4;
            if (rvalid === ex.v) n_pass++; else $display("FAIL word[%0d] rvalid got %0b want %0b", i, rvalid, ex.v);
            if (err === ex.e) n_pass++; else $display("FAIL word[%0d] err got %0b want %0b", i, err, ex.e);
            if (rdata === ex.d) n_pass++; else $display("FAIL word[%0d] rdata got %08h want %08h", i, rdata, ex.d);
            if (rdata_2 === ex.d2) n_pass++; else $display("FAIL word[%0d] rdata_2 got %08h want %08h", i, rdata_2, ex.d2);
        end
        n_checks++;
        if (rdata === 32'hDEADBEEF) n_pass++; else $display("FAIL word_const rdata got %08h want deadbeef", rdata);
        req = 1'b0;
    endtask

    task automatic test_byte_half();
        logic        tw [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [2:0]  tc [7] = '{3'b010, 3'b000, 3'b001, 3'b010, 3'b000, 3'b100, 3'b001};
        logic [31:0] ta [7] = '{32'h8, 32'h9, 32'hA, 32'h8, 32'hB, 32'hB, 32'hA};
        logic [31:0] td [7] = '{32'h0, 32'h7F, 32'h8001, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] want [7] = '{32'h0, 32'h0, 32'h0, 32'h80017F00, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
        for (int i = 0; i < 7; i++) begin
            send(tw[i], tc[i], ta[i], td[i], 32'h8);
            ex = sb.pop_front();
            n_checks += 4;
            if (rvalid === ex.v) n_pass++; else $display("FAIL bh[%0d] rvalid got %0b want %0b", i, rvalid, ex.v);
            if (err === ex.e) n_pass++; else $display("FAIL bh[%0d] err got %0b want %0b", i, err, ex.e);
            if (rdata === ex.d) n_pass++; else $display("FAIL bh[%0d] rdata got %08h want %08h", i, rdata, ex.d);
            if (rdata_2 === ex.d2) n_pass++; else $display("FAIL bh[%0d] rdata_2 got %08h want %08h", i, rdata_2, ex.d2);
            if (i >= 3) begin
                n_checks++;
                if (rdata === want[i]) n_pass++; else $display("FAIL bh_const[%0d] rdata got %08h want %08h", i, rdata, want[i]);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_misaligned();
        logic        tw [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  tc [8] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b010, 3'b101, 3'b010};
        logic [31:0] ta [8] = '{32'h3, 32'h2, 32'h8, 32'h8, 32'h8, 32'h8, 32'hC, 32'hC};
        for (int i = 0; i < 8; i++) begin
            send(tw[i], tc[i], ta[i], 32'h5555ABCD, 32'h8);
            ex = sb.pop_front();
            n_checks += 4;
            if (rvalid === ex.v) n_pass++; else $display("FAIL mis[%0d] rvalid got %0b want %0b", i, rvalid, ex.v);
            if (err === ex.e) n_pass++; else $display("FAIL mis[%0d] err got %0b want %0b", i, err, ex.e);
            if (rdata === ex.d) n_pass++; else $display("FAIL mis[%0d] rdata got %08h want %08h", i, rdata, ex.d);
            if (rdata_2 === ex.d2) n_pass++; else $display("FAIL mis[%0d] rdata_2 got %08h want %08h", i, rdata_2, ex.d2);
            if (i == 5) begin
                n_checks++;
                if (rdata === 32'h80017F00) n_pass++; else $display("FAIL mis_unchanged rdata got %08h want 80017f00", rdata);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_port2();
        logic        tw [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] ta [3] = '{32'h10, 32'h50, 32'h54};
        logic [31:0] td [3] = '{32'h12345678, 32'h0, 32'hCAFEF00D};
        logic [31:0] t2 [3] = '{32'h10, 32'h52, 32'h17};
        for (int i = 0; i < 3; i++) begin
            send(tw[i], 3'b010, ta[i], td[i], t2[i]);
            ex = sb.pop_front();
            n_checks += 4;
            if (rvalid === ex.v) n_pass++; else $display("FAIL p2[%0d] rvalid got %0b want %0b", i, rvalid, ex.v);
            if (err === ex.e) n_pass++; else $display("FAIL p2[%0d] err got %0b want %0b", i, err, ex.e);
            if (rdata === ex.d) n_pass++; else $display("FAIL p2[%0d] rdata got %08h want %08h", i, rdata, ex.d);
            if (rdata_2 === ex.d2) n_pass++; else $display("FAIL p2[%0d] rdata_2 got %08h want %08h", i, rdata_2, ex.d2);
            if (i == 0) begin
                n_checks++;
                if (rdata_2 === 32'h12345678) n_pass++; else $display("FAIL p2_wfirst rdata_2 got %08h want 12345678", rdata_2);
            end
            if (i == 1) begin
                n_checks++;
                if (rdata === 32'h12345678) n_pass++; else $display("FAIL p2_alias rdata got %08h want 12345678", rdata);
            end
            if (i == 2) begin
                n_checks++;
                if (rdata_2 === 32'hCAFEF00D) n_pass++; else $display("FAIL p2_alias_wfirst rdata_2 got %08h want cafef00d", rdata_2);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] c;
        for (int i = 0; i < 48; i++) begin
            c = 3'($urandom_range(0, 7));
            send(1'($urandom_range(0, 1)), c, $urandom, $urandom, $urandom);
            ex = sb.pop_front();
            n_checks += 4;
            if (rvalid === ex.v) n_pass++; else $display("FAIL b2b[%0d] rvalid got %0b want %0b", i, rvalid, ex.v);
            if (err === ex.e) n_pass++; else $display("FAIL b2b[%0d] err got %0b want %0b", i, err, ex.e);
            if (rdata === ex.d) n_pass++; else $display("FAIL b2b[%0d] rdata got %08h want %08h", i, rdata, ex.d);
            if (rdata_2 === ex.d2) n_pass++; else $display("FAIL b2b[%0d] rdata_2 got %08h want %08h", i, rdata_2, ex.d2);
        end
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 3'b010, 32'(i * 4), 32'hA5000000 | 32'(i), 32'h0);
            void'(sb.pop_front());
        end
        req = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        rst_n = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            req = 1'b1; we = 1'(i % 2); ctrl = (i % 3 == 0) ? 3'b011 : 3'b010;
            addr = 32'h8; wdata = 32'hFFFFFFFF;
            @(posedge clk); #1;
            $display("txn pre-ready we=%0b ctrl=%03b -> ready=%0b rvalid=%0b err=%0b", we, ctrl, ready, rvalid, err);
            n_checks += 3;
            if (ready === 1'b0) n_pass++; else $display("FAIL midclr_ready[%0d] got %0b want 0", i, ready);
            if (rvalid === 1'b0) n_pass++; else $display("FAIL midclr_rvalid[%0d] got %0b want 0", i, rvalid);
            if (err === 1'b0) n_pass++; else $display("FAIL midclr_err[%0d] got %0b want 0", i, err);
        end
        rst_n = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        hold_m = '0;
        rst_n  = 1'b1;
        wait_ready(n);
        n_checks++;
        if (n == 16) n_pass++; else $display("FAIL midclr_restart got %0d cycles want 16", n);
        for (int i = 0; i < 16; i++) begin
            send(1'b0, 3'b010, 32'(i * 4), 32'h0, 32'(60 - i * 4));
            ex = sb.pop_front();
            n_checks += 3;
            if (rvalid === ex.v) n_pass++; else $display("FAIL reclr[%0d] rvalid got %0b want %0b", i, rvalid, ex.v);
            if (rdata === ex.d) n_pass++; else $display("FAIL reclr[%0d] rdata got %08h want %08h", i, rdata, ex.d);
            if (rdata_2 === ex.d2) n_pass++; else $display("FAIL reclr[%0d] rdata_2 got %08h want %08h", i, rdata_2, ex.d2);
        end
        req = 1'b0;
    endtask

    initial begin
        mdl_clear();
        test_reset();
        test_word();
        test_byte_half();
        test_misaligned();
        test_port2();
        test_back_to_back();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
